lcd_driver: RTL and testbench

- Timing generator directly upstream of the LCD character/pattern display stage.
- Runs free-running horizontal and vertical counters and produces HS, VS and DE for the panel.
- Issues a look-ahead pixel request with lcd_xpos/lcd_ypos to the display stage, which returns lcd_data after its 2-cycle ROM plus register latency.
- Gates the returned 24-bit colour onto the panel RGB bus during the active area only.

---
 rtl/lcd_driver.sv | 132 +++++++++++++
 tb/tb_lcd_driver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_driver.sv
`default_nettype none
// ============================================================================
// lcd_driver : LCD panel timing generator (HS/VS/DE, look-ahead pixel request)
// Rev 1.0
// ============================================================================
module lcd_driver #(
   parameter int   H_SYNC     = 96,
   parameter int   H_BACK     = 48,
   parameter int   H_DISP     = 640,
   parameter int   H_FRONT    = 16,
   parameter int   V_SYNC     = 2,
   parameter int   V_BACK     = 33,
   parameter int   V_DISP     = 480,
   parameter int   V_FRONT    = 10,
   parameter logic SYNC_POL   = 1'b0,
   parameter int   ADDR_AHEAD = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        timing_en,
   input  logic [23:0] lcd_data,
   output logic        lcd_request,
   output logic [10:0] lcd_xpos,
   output logic [10:0] lcd_ypos,
   output logic        lcd_hs,
   output logic        lcd_vs,
   output logic        lcd_en,
   output logic [23:0] lcd_rgb,
   output logic        frame_done
);

   // Bounds are 12 bits so an end bound of exactly 2048 still compares correctly.
   localparam logic [11:0] c_h_last    = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
   localparam logic [11:0] c_v_last    = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
   localparam logic [11:0] c_h_sync    = 12'(H_SYNC);
   localparam logic [11:0] c_v_sync    = 12'(V_SYNC);
   localparam logic [11:0] c_ha        = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] c_ha_end    = 12'(H_SYNC + H_BACK + H_DISP);
   localparam logic [11:0] c_va        = 12'(V_SYNC + V_BACK);
   localparam logic [11:0] c_va_end    = 12'(V_SYNC + V_BACK + V_DISP);
   localparam logic [11:0] c_req_start = 12'(H_SYNC + H_BACK - ADDR_AHEAD);
   localparam logic [11:0] c_req_end   = 12'(H_SYNC + H_BACK + H_DISP - ADDR_AHEAD);

   logic [10:0] hcnt_q, hcnt_d;
   logic [10:0] vcnt_q, vcnt_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        en_q, en_d;
   logic        req_q, req_d;
   logic        fd_q, fd_d;
   logic [10:0] xpos_q, xpos_d;
   logic [10:0] ypos_q, ypos_d;

   logic [11:0] w_h;
   logic [11:0] w_v;
   logic        w_vact;
   logic        w_req;

   assign w_h    = {1'b0, hcnt_q};
   assign w_v    = {1'b0, vcnt_q};
   assign w_vact = (w_v >= c_va) && (w_v < c_va_end);
   assign w_req  = w_vact && (w_h >= c_req_start) && (w_h < c_req_end);

   always_comb begin
      hcnt_d = hcnt_q + 11'd1;
      vcnt_d = vcnt_q;
      if (w_h == c_h_last) begin
         hcnt_d = '0;
         vcnt_d = (w_v == c_v_last) ? 11'd0 : vcnt_q + 11'd1;
      end
      if (!timing_en) begin
         hcnt_d = '0;
         vcnt_d = '0;
      end
   end

   // Registered decodes of the current counters; inactive while timing is held.
   always_comb begin
      hs_d   = ~SYNC_POL;
      vs_d   = ~SYNC_POL;
      en_d   = 1'b0;
      req_d  = 1'b0;
      fd_d   = 1'b0;
      xpos_d = '0;
      ypos_d = '0;
      if (timing_en) begin
         hs_d   = (w_h < c_h_sync) ? SYNC_POL : ~SYNC_POL;
         vs_d   = (w_v < c_v_sync) ? SYNC_POL : ~SYNC_POL;
         en_d   = w_vact && (w_h >= c_ha) && (w_h < c_ha_end);
         req_d  = w_req;
         fd_d   = (w_h == c_h_last) && (w_v == c_v_last);
         xpos_d = w_req  ? (hcnt_q - c_req_start[10:0]) : 11'd0;
         ypos_d = w_vact ? (vcnt_q - c_va[10:0])        : 11'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
         hs_q   <= ~SYNC_POL;
         vs_q   <= ~SYNC_POL;
         en_q   <= 1'b0;
         req_q  <= 1'b0;
         fd_q   <= 1'b0;
         xpos_q <= '0;
         ypos_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         en_q   <= en_d;
         req_q  <= req_d;
         fd_q   <= fd_d;
         xpos_q <= xpos_d;
         ypos_q <= ypos_d;
      end
   end

   assign lcd_hs      = hs_q;
   assign lcd_vs      = vs_q;
   assign lcd_en      = en_q;
   assign lcd_request = req_q;
   assign frame_done  = fd_q;
   assign lcd_xpos    = xpos_q;
   assign lcd_ypos    = ypos_q;
   // Display stage latency equals ADDR_AHEAD, so returned data lines up with DE.
   assign lcd_rgb     = en_q ? lcd_data : 24'h0;

endmodule
`default_nettype wire

// File: tb/tb_lcd_driver.sv
`default_nettype none
// ============================================================================
// tb_lcd_driver : self-checking bench for lcd_driver (small 17x8 raster)
// Rev 1.0
// ============================================================================
module tb_lcd_driver;

   localparam int HS = 4, HB = 3, HD = 8, HF = 2;
   localparam int VS = 2, VB = 1, VD = 4, VF = 1;
   localparam int AH = 2;
   localparam int HT = HS + HB + HD + HF;
   localparam int VT = VS + VB + VD + VF;
   localparam int HA = HS + HB;
   localparam int VA = VS + VB;
   localparam int FRAME = HT * VT;
   localparam int NREC = 300;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        timing_en = 1'b1;
   logic [23:0] lcd_data;
   logic        lcd_request, lcd_hs, lcd_vs, lcd_en, frame_done;
   logic [10:0] lcd_xpos, lcd_ypos;
   logic [23:0] lcd_rgb;

   int checks = 0;
   int errors = 0;
   logic cmp_on = 1'b0;

   always #5 clk = ~clk;

   lcd_driver #(
      .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
      .SYNC_POL(1'b0), .ADDR_AHEAD(AH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .timing_en(timing_en), .lcd_data(lcd_data),
      .lcd_request(lcd_request), .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos),
      .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_en(lcd_en),
      .lcd_rgb(lcd_rgb), .frame_done(frame_done)
   );

   // Display stage: returns {13'h0, xpos} two clocks after a request, junk otherwise.
   logic        req_d1, req_d2;
   logic [10:0] x_d1, x_d2;
   logic [23:0] noise;
   always @(posedge clk) begin
      req_d1 <= lcd_request;
      req_d2 <= req_d1;
      x_d1   <= lcd_xpos;
      x_d2   <= x_d1;
      noise  <= 24'($urandom) | 24'h000100;
   end
   assign lcd_data = req_d2 ? {13'h0, x_d2} : noise;

   // Reference model: raster position p since frame start, decoded arithmetically.
   typedef struct packed {
      logic        hs, vs, en, req, fd;
      logic [10:0] x, y, col;
   } exp_t;

   localparam exp_t IDLE = '{hs: 1'b1, vs: 1'b1, en: 1'b0, req: 1'b0, fd: 1'b0,
                             x: 11'd0, y: 11'd0, col: 11'd0};

   function automatic exp_t decode(input int p);
      int   h, v;
      logic vact;
      exp_t e;
      h      = p % HT;
      v      = p / HT;
      vact   = (v >= VA) && (v < VA + VD);
      e.hs   = !(h < HS);
      e.vs   = !(v < VS);
      e.en   = vact && (h >= HA) && (h < HA + HD);
      e.req  = vact && (h >= HA - AH) && (h < HA + HD - AH);
      e.fd   = (p == FRAME - 1);
      e.x    = e.req ? 11'(h - (HA - AH)) : 11'd0;
      e.y    = vact ? 11'(v - VA) : 11'd0;
      e.col  = e.en ? 11'(h - HA) : 11'd0;
      return e;
   endfunction

   int   m_p;
   exp_t m_out;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_p   <= 0;
         m_out <= IDLE;
      end else if (timing_en) begin
         m_out <= decode(m_p);
         m_p   <= (m_p + 1) % FRAME;
      end else begin
         m_p   <= 0;
         m_out <= IDLE;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("model_outputs",
             64'({lcd_hs, lcd_vs, lcd_en, lcd_request, frame_done, lcd_xpos, lcd_ypos}),
             64'({m_out.hs, m_out.vs, m_out.en, m_out.req, m_out.fd, m_out.x, m_out.y}));
         chk("model_rgb", 64'(lcd_rgb), 64'(m_out.en ? {13'h0, m_out.col} : 24'h0));
      end
   end

   logic        r_hs [1:NREC];
   logic        r_vs [1:NREC];
   logic        r_req[1:NREC];
   logic        r_en [1:NREC];
   logic        r_fd [1:NREC];
   logic [10:0] r_x  [1:NREC];
   logic [10:0] r_y  [1:NREC];
   logic [23:0] r_rgb[1:NREC];

   initial begin
      #1 rst_n = 1'b0;
      cmp_on = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_hs", 64'(lcd_hs), 64'd1);
      chk("reset_vs", 64'(lcd_vs), 64'd1);
      chk("reset_en", 64'(lcd_en), 64'd0);
      chk("reset_rgb", 64'(lcd_rgb), 64'd0);
      rst_n = 1'b1;

      for (int i = 1; i <= NREC; i++) begin
         @(negedge clk);
         r_hs[i] = lcd_hs;   r_vs[i] = lcd_vs;  r_req[i] = lcd_request;
         r_en[i] = lcd_en;   r_fd[i] = frame_done;
         r_x[i]  = lcd_xpos; r_y[i]  = lcd_ypos; r_rgb[i] = lcd_rgb;
      end

      begin
         int hs_len, vs_len, req_first, en_first, req_cnt, fd_cnt, fd_a, fd_b, leak;
         hs_len = 0; vs_len = 0; req_first = 0; en_first = 0;
         req_cnt = 0; fd_cnt = 0; fd_a = 0; fd_b = 0; leak = 0;
         while (hs_len < NREC && r_hs[hs_len + 1] == 1'b0) hs_len++;
         while (vs_len < NREC && r_vs[vs_len + 1] == 1'b0) vs_len++;
         for (int i = 1; i <= NREC; i++) begin
            if (r_req[i] && req_first == 0) req_first = i;
            if (r_en[i] && en_first == 0) en_first = i;
            if (r_req[i] && i <= FRAME) req_cnt++;
            if (r_fd[i]) begin
               fd_cnt++;
               if (fd_a == 0) fd_a = i; else if (fd_b == 0) fd_b = i;
            end
            if (!r_en[i] && r_rgb[i] != 24'h0) leak++;
         end
         chk("hs_low_len", 64'(hs_len), 64'd4);
         chk("vs_low_len", 64'(vs_len), 64'd34);
         chk("req_first_edge", 64'(req_first), 64'd57);
         chk("en_lag", 64'(en_first - req_first), 64'd2);
         chk("ypos_first_line", 64'(r_y[59]), 64'd0);
         chk("ypos_last_line", 64'(r_y[57 + 3 * 17]), 64'd3);
         chk("req_per_frame", 64'(req_cnt), 64'd32);
         for (int k = 0; k < 8; k++) begin
            chk("xpos_seq", 64'(r_x[57 + k]), 64'(k));
            chk("rgb_seq", 64'(r_rgb[59 + k]), 64'(k));
         end
         chk("fd_first", 64'(fd_a), 64'd136);
         chk("fd_period", 64'(fd_b - fd_a), 64'd136);
         chk("fd_count", 64'(fd_cnt), 64'd2);
         chk("rgb_gated", 64'(leak), 64'd0);
      end

      // Drop timing_en mid-line 4 for five clocks.
      begin
         int n;
         n = 0;
         while (m_p != 4 * HT + 8 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
         end
         if (n >= 3 * FRAME) chk("wait_line4_timeout", 64'd1, 64'd0);
         timing_en = 1'b0;
         @(negedge clk);
         chk("drop_outputs", 64'({lcd_en, lcd_request, lcd_hs, lcd_vs}), 64'b0011);
         repeat (4) @(negedge clk);
         timing_en = 1'b1;
         @(negedge clk);
         chk("restart_sync", 64'({lcd_hs, lcd_vs, lcd_ypos}), 64'd0);
      end

      // Asynchronous reset while a pixel is on the bus.
      begin
         int n;
         n = 0;
         while (lcd_en !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
         end
         if (n >= 2 * FRAME) chk("wait_en_timeout", 64'd1, 64'd0);
         #2 rst_n = 1'b0;
         #1 chk("async_rst_en_rgb", 64'({lcd_en, lcd_rgb}), 64'd0);
         @(negedge clk);
         rst_n = 1'b1;
         repeat (FRAME + 20) @(negedge clk);
      end

      for (int it = 0; it < 24; it++) begin
         int len;
         len = $urandom_range(40, 320);
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            timing_en = ($urandom_range(0, 99) < 97);
         end
         if ($urandom_range(0, 2) == 0) begin
            #($urandom_range(1, 4)) rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
         end
      end
      timing_en = 1'b1;
      repeat (2 * FRAME) @(negedge clk);

      cmp_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
